// File: rtl/gsc_pkg.sv
// rtl/gsc_pkg.sv - shared types and constants for the green-screen controller
package gsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        AUTO = 2'd2
    } gsc_state_t;

    localparam int HUE_MOD = 360;
    localparam int HUE_W   = 9;
    localparam int BG_W    = 2;

endpackage

// File: rtl/gsc_debounce.sv
// rtl/gsc_debounce.sv - key synchroniser, stability counter and press pulse
module gsc_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Until armed, the counter also times a stable release so that a key held
    // through reset cannot turn into a press.
    always_comb begin
        s1_d    = key_n;
        s2_d    = s1_q;
        db_d    = db_q;
        armed_d = armed_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if ((s2_q != db_q) || (!armed_q && s2_q)) begin
            if (cnt_q == CNT_LAST) begin
                if (s2_q != db_q) begin
                    db_d    = s2_q;
                    press_d = armed_q & ~s2_q;
                end else begin
                    armed_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            armed_q <= armed_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/gsc_ctrl.sv
// rtl/gsc_ctrl.sv - frame-synchronous keying/background/hue controller
module gsc_ctrl
    import gsc_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int FRAME_DIV = 60,
    parameter int HUE_STEP  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_en_n,
    input  logic            key_bg_n,
    input  logic            auto_en,
    input  logic            vsync,
    output logic            gsc_en,
    output logic [BG_W-1:0] bg_sel,
    output logic [HUE_W-1:0] hue_ofs,
    output logic            frame_tick
);

    localparam int FC_W = $clog2(FRAME_DIV + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);

    logic press_en, press_bg;

    gsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_en (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_en_n),
        .press (press_en)
    );

    gsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_bg (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_bg_n),
        .press (press_bg)
    );

    logic             vs1_q, vs1_d, vs2_q, vs2_d, vs_prev_q, vs_prev_d;
    logic             au1_q, au1_d, au2_q, au2_d;
    logic             pend_tog_q, pend_tog_d;
    logic [BG_W-1:0]  pend_bg_q, pend_bg_d;
    gsc_state_t       state_q, state_d, nxt;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             gsc_en_q, gsc_en_d;
    logic [BG_W-1:0]  bg_q, bg_d;
    logic [HUE_W-1:0] hue_q, hue_d;
    logic             tick_q, tick_d;
    logic             boundary, step;
    logic [HUE_W:0]   hue_sum;

    always_comb begin
        vs1_d      = vsync;
        vs2_d      = vs1_q;
        vs_prev_d  = vs2_q;
        au1_d      = auto_en;
        au2_d      = au1_q;
        pend_tog_d = pend_tog_q ^ press_en;
        pend_bg_d  = pend_bg_q + BG_W'(press_bg);
        state_d    = state_q;
        fcnt_d     = (state_q == AUTO) ? fcnt_q : '0;
        gsc_en_d   = gsc_en_q;
        bg_d       = bg_q;
        hue_d      = hue_q;
        tick_d     = 1'b0;
        boundary   = vs2_q & ~vs_prev_q;
        step       = (state_q == AUTO) && (fcnt_q == FC_LAST);
        hue_sum    = {1'b0, hue_q} + (HUE_W + 1)'(HUE_STEP);

        nxt = state_q;
        case (state_q)
            IDLE:    if (pend_tog_q) nxt = au2_q ? AUTO : MAN;
            MAN:     if (pend_tog_q) nxt = IDLE; else if (au2_q) nxt = AUTO;
            AUTO:    if (pend_tog_q) nxt = IDLE; else if (!au2_q) nxt = MAN;
            default: nxt = IDLE;
        endcase

        // A press landing on the boundary cycle seeds the next frame's pending.
        if (boundary) begin
            pend_tog_d = press_en;
            pend_bg_d  = BG_W'(press_bg);
            state_d    = nxt;
            if (nxt == AUTO) begin
                fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + FC_W'(1);
            end else begin
                fcnt_d = '0;
            end
            gsc_en_d = (nxt != IDLE);
            bg_d     = bg_q + pend_bg_q + BG_W'(step);
            if (nxt == IDLE) begin
                hue_d = '0;
            end else if (hue_sum >= (HUE_W + 1)'(HUE_MOD)) begin
                hue_d = HUE_W'(hue_sum - (HUE_W + 1)'(HUE_MOD));
            end else begin
                hue_d = HUE_W'(hue_sum);
            end
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            vs_prev_q  <= 1'b0;
            au1_q      <= 1'b0;
            au2_q      <= 1'b0;
            pend_tog_q <= 1'b0;
            pend_bg_q  <= '0;
            state_q    <= IDLE;
            fcnt_q     <= '0;
            gsc_en_q   <= 1'b0;
            bg_q       <= '0;
            hue_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            vs_prev_q  <= vs_prev_d;
            au1_q      <= au1_d;
            au2_q      <= au2_d;
            pend_tog_q <= pend_tog_d;
            pend_bg_q  <= pend_bg_d;
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            gsc_en_q   <= gsc_en_d;
            bg_q       <= bg_d;
            hue_q      <= hue_d;
            tick_q     <= tick_d;
        end
    end

    assign gsc_en     = gsc_en_q;
    assign bg_sel     = bg_q;
    assign hue_ofs    = hue_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/gsc_ctrl.md
# gsc_ctrl

Frame-synchronous controller for the green-screen keying stage. Turns two raw pushbuttons and an auto-cycle switch into the stage's `gsc_en` / `bg_sel` controls and a per-frame hue offset. All control changes are committed only at frame boundaries (vsync), so a frame is never keyed with mixed settings. It sits between the board I/O (KEY/SW) and the green-screen pixel stage, in the pixel clock domain.

## Interface
- `DB_CYCLES`, default 500000: cycles a key must be stable before its debounced level changes (≥2).
- `FRAME_DIV`, default 60: frames per background step in auto mode (≥1).
- `HUE_STEP`, default 2: hue offset increment per frame, range 0..359.
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_en_n`  in  1: raw pushbutton, active-low, asynchronous; a press toggles keying.
- `key_bg_n`  in  1: raw pushbutton, active-low, asynchronous; a press advances the background.
- `auto_en`  in  1: raw switch level, asynchronous; selects auto-cycle.
- `vsync`  in  1: frame-start level, asynchronous; its rising edge marks a frame boundary.
- `gsc_en`  out  1: keying enable to the green-screen stage; reset 0.
- `bg_sel`  out  2: background pattern select; reset 0.
- `hue_ofs`  out  9: hue offset, 0..359; reset 0.
- `frame_tick`  out  1: one-cycle pulse on every commit; reset 0.

## Operation
- **Synchronisers.** All four async inputs pass through 2-FF synchronisers (reset 0 for `vsync` and `auto_en`, reset 1 for the keys). The boundary pulse is `vs_s2 & ~vs_prev`.
- **Debounce (per key).**
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches `DB_CYCLES-1`, the debounced level takes the synced value and the counter clears.
  - The press event is a one-cycle pulse on a debounced 1→0 transition.
- **Pending accumulators** (cleared at every boundary):
  - An `key_en` press toggles `pend_tog`.
  - A `key_bg` press increments `pend_bg` (2-bit, mod 4).
  - A press coinciding with the boundary cycle is accumulated into the *next* frame's pending, never lost.
- **FSM** (states `IDLE`, `MAN`, `AUTO`; reset `IDLE`). It evaluates only on the boundary pulse:
  - `IDLE`: `pend_tog` → `AUTO` if `auto_en` is set, else `MAN`; otherwise stay.
  - `MAN`: `pend_tog` → `IDLE`; else `auto_en` → `AUTO`; else stay.
  - `AUTO`: `pend_tog` → `IDLE`; else `!auto_en` → `MAN`; else stay.
- **frame_cnt.** Counts boundaries while the current state is `AUTO`, wrapping `FRAME_DIV-1`→0. It clears in any other state.
- **Commit at boundary.**
  - `gsc_en` = (next state ≠ `IDLE`).
  - `bg_sel` = `bg_sel + pend_bg + step` mod 4, where `step` = (state==`AUTO` && frame_cnt==`FRAME_DIV-1`). Manual and auto steps in the same frame add. `pend_bg` also applies in `IDLE`, as a pre-select.
  - `hue_ofs`: if next state is `IDLE` → 0. Otherwise compute `hue_ofs + HUE_STEP` in 10 bits and subtract 360 if ≥360.
  - `frame_tick` = 1 for that cycle.
- **Reset mid-operation.** Asserting `rst_n` low immediately clears all state, including debounce counters and pending accumulators. A key held through reset release produces no press, because the debounced level starts at 1 and must first see a stable release.

## Timing
- Outputs change only on the clock edge at which the boundary pulse is high. That is the 3rd rising edge after `vsync` rises, given setup is met at edge 1.
- Boundary pulses are at least 2 cycles apart per frame. `vsync` high longer than one cycle gives exactly one commit.
- A key press becomes pending `DB_CYCLES + 2` cycles after the raw edge (with a stable input). It is committed at the next boundary after that.
- `auto_en` is sampled synchronously; its value at the boundary cycle is used.
- No output is combinational from any input.

## Structure
- `gsc_pkg`:
  - state enum `gsc_state_t` {IDLE, MAN, AUTO};
  - constant `HUE_MOD = 360`;
  - width constants `HUE_W = 9`, `BG_W = 2`.
- Sub-module `gsc_debounce` (synchroniser + counter + press-pulse), instantiated twice and parameterised by `DB_CYCLES`.
- The `auto_en` and `vsync` synchronisers are inline in `gsc_ctrl`.

## Test plan
All scenarios use `DB_CYCLES`=4, `FRAME_DIV`=3, `HUE_STEP`=100.

- **Enable toggle.** After reset, one `key_en_n` press, then a vsync → `gsc_en` goes 1 at the 3rd edge after vsync, `frame_tick` pulses once, `hue_ofs`=100. A second press plus vsync → `gsc_en`=0 and `hue_ofs`=0.
- **Debounce.** Bounce `key_bg_n` with 3-cycle low glitches, then hold low for 10 cycles, then vsync → `bg_sel`=1 (exactly one increment). Glitches alone plus vsync → `bg_sel` unchanged.
- **Accumulation and wrap.** Five `key_bg` presses in one frame → `bg_sel` goes 0→1 at the boundary. Also check the boundary-cycle press: it lands in the following frame.
- **Auto cycling and hue wrap.** `auto_en`=1, enable, then 6 vsyncs:
  - `bg_sel` steps at frames 3 and 6 (0→1→2);
  - `hue_ofs` sequence is 100, 200, 300, 40, 140, 240.
- **Simultaneous steps.** One manual `key_bg` press in the frame where auto steps → `bg_sel` +2 at that boundary. Drop `auto_en` mid-run → state becomes `MAN`, `frame_cnt` clears, and no further auto steps occur.
- **Reset mid-operation.** Assert `rst_n` low between a press and its vsync → all outputs 0 immediately. After release, with the key still held, a vsync causes no change.
